// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU opcodes,
// and the legal-opcode check.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [2:0] ALU_OP_CMP = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b100;

    // Wide enough for the largest supported requester count (8).
    localparam int IDX_W = 3;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == ALU_OP_CMP) || (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin pick over NUM_REQ request lines with a registered last-winner
// pointer; the update strobe also steers the search base in the same cycle.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    input  logic [IDX_W-1:0]   upd_idx,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0]   ptr_q, ptr_d, base;
    logic [NUM_REQ-1:0] rot;
    int                 cand;

    // Scan farthest-first so the nearest requester above the base wins last.
    always_comb begin
        base    = upd ? upd_idx : ptr_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        rot     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(base) + i) % NUM_REQ;
            rot  = req >> cand;
            if (rot[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = upd ? upd_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU among NUM_REQ requesters.
// Define ALU_ARB_TIMEOUT_EN to build the ISSUE-phase timeout abort.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                      i_SCLK,
    input  logic                      i_RESET,
    input  logic [NUM_REQ-1:0]        i_REQ,
    input  logic [3*NUM_REQ-1:0]      i_OP,
    input  logic [DATA_W*NUM_REQ-1:0] i_RX,
    input  logic [DATA_W*NUM_REQ-1:0] i_RY,
    output logic [NUM_REQ-1:0]        o_GNT,
    output logic [NUM_REQ-1:0]        o_DONE,
    output logic [DATA_W-1:0]         o_RESULT,
    output logic                      o_ERR,
    output logic [2:0]                o_ALU_ENABLE,
    output logic [DATA_W-1:0]         o_ALU_RX,
    output logic [DATA_W-1:0]         o_ALU_RY,
    input  logic                      i_ALU_READY,
    input  logic [DATA_W-1:0]         i_ALU_RESULT
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("alu_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   rx_q, rx_d, ry_q, ry_d, res_q, res_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;

    logic [NUM_REQ-1:0]  arb_req;
    logic                arb_vld, arb_upd;
    logic [IDX_W-1:0]    arb_idx;
    logic [2:0]          sel_op;
    logic [DATA_W-1:0]   sel_rx, sel_ry;
    logic                tmo_hit;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (state_q != ST_ISSUE) begin
            tmo_d = '0;
        end else if (tmo_q != TO_W'(TIMEOUT - 1)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_ISSUE) && (tmo_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge i_SCLK) begin
        if (i_RESET) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // The requester being completed is masked so a held request cannot win twice in a row.
    assign arb_req = (state_q == ST_DONE) ? (i_REQ & ~gnt_q) : i_REQ;
    assign arb_upd = (state_q == ST_DONE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (i_SCLK),
        .rst     (i_RESET),
        .req     (arb_req),
        .upd     (arb_upd),
        .upd_idx (idx_q),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        sel_op = '0;
        sel_rx = '0;
        sel_ry = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                sel_op = i_OP[3*k +: 3];
                sel_rx = i_RX[DATA_W*k +: DATA_W];
                sel_ry = i_RY[DATA_W*k +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        res_d   = res_q;
        err_d   = err_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
            end
            ST_ISSUE: begin
                if (i_ALU_READY) begin
                    res_d   = i_ALU_RESULT;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        // Granting from DONE as well keeps back-to-back service at one op per 5 cycles.
        if ((state_q == ST_IDLE || state_q == ST_DONE) && arb_vld) begin
            idx_d = arb_idx;
            op_d  = sel_op;
            rx_d  = sel_rx;
            ry_d  = sel_ry;
            gnt_d = NUM_REQ'(1) << arb_idx;
            if (op_legal(sel_op)) begin
                err_d   = 1'b0;
                state_d = ST_ISSUE;
            end else begin
                err_d   = 1'b1;
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge i_SCLK) begin
        if (i_RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            res_q   <= res_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
        end
    end

    assign o_GNT        = gnt_q;
    assign o_DONE       = (state_q == ST_DONE) ? gnt_q : '0;
    assign o_RESULT     = res_q;
    assign o_ERR        = err_q;
    assign o_ALU_ENABLE = (state_q == ST_ISSUE) ? op_q : 3'b000;
    assign o_ALU_RX     = rx_q;
    assign o_ALU_RY     = ry_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 16-bit ALU among `NUM_REQ` requesters. It grants one requester at a time and drives the ALU's operands and one-hot enable. It holds the enable until the ALU's ready pulse, then captures the result, returns it to the requester with a one-cycle done strobe, and releases the enable so the ALU returns to idle. It sits between the processing units and the ALU, and is the only driver of the ALU's enable and operand inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 16: operand and result width; must match the ALU.
- `TIMEOUT`, default 15: maximum number of ISSUE cycles before abort. Used only with `ALU_ARB_TIMEOUT_EN`.
- `i_SCLK`  in  1  single clock; all logic on the rising edge.
- `i_RESET`  in  1  synchronous, active-high reset.
- `i_REQ`  in  NUM_REQ  per-requester request level; held until the matching `o_DONE`.
- `i_OP`  in  3*NUM_REQ  per-requester opcode, slice k = bits [3k+2:3k]: 001 compare, 010 add, 100 sub.
- `i_RX`, `i_RY`  in  DATA_W*NUM_REQ  per-requester operands, slice k.
- `o_GNT`  out  NUM_REQ  one-hot grant; high from grant through DONE inclusive.
- `o_DONE`  out  NUM_REQ  one-cycle completion strobe to the served requester.
- `o_RESULT`  out  DATA_W  result of the last completed operation; valid while `o_DONE` is high and held afterwards.
- `o_ERR`  out  1  qualifies `o_DONE`: 1 means illegal opcode or timeout.
- `o_ALU_ENABLE`  out  3  one-hot opcode to the ALU.
- `o_ALU_RX`, `o_ALU_RY`  out  DATA_W  latched operands to the ALU.
- `i_ALU_READY`  in  1  ALU completion pulse.
- `i_ALU_RESULT`  in  DATA_W  ALU result.

## Operation
- **States:** IDLE, ISSUE, DONE.
- **IDLE:**
  - If any `i_REQ` bit is set, pick the winner by round-robin, searching upward from the last granted index + 1 with wrap.
  - Latch the winner's index, opcode and operands, and assert `o_GNT`.
  - If the opcode is legal (exactly one bit set), go to ISSUE.
  - Otherwise set `o_ERR`=1 and go to DONE without touching the ALU.
- **ISSUE:**
  - `o_ALU_ENABLE` = latched opcode; operands stay stable.
  - On `i_ALU_READY`=1, capture `i_ALU_RESULT` into `o_RESULT`, set `o_ERR`=0 and go to DONE.
- **DONE:**
  - `o_ALU_ENABLE`=0, which releases the ALU from its WAIT state.
  - `o_DONE[winner]`=1 for exactly one cycle.
  - Update the round-robin pointer to the winner, then return to IDLE.
- **Request handling:**
  - `i_REQ` of the winner is ignored during DONE.
  - If the requester still holds `i_REQ` in the following IDLE cycle, that is a new request.
  - Requests changing in ISSUE or DONE have no effect until IDLE.
- **Reset values:** state IDLE; RR pointer = NUM_REQ-1, so requester 0 has first priority. All outputs 0, including `o_ALU_ENABLE`, operands, `o_RESULT` and `o_ERR`.
- **Reset mid-operation:** the arbiter abandons the operation and produces no `o_DONE`. With enable at 0, the ALU drains WAIT→IDLE by itself.

## Timing
- Request sampled at edge E0: `o_ALU_ENABLE` is valid after E0.
- The ALU ready pulse is seen in the cycle after E3.
- The result is captured at E4, and `o_DONE` is high in cycle E4–E5.
- Request-to-done latency is 4 cycles; the earliest next grant is at E5.
- Back-to-back throughput is one operation per 5 cycles.
- An illegal opcode completes with `o_DONE` in the cycle after grant, i.e. 1 cycle of latency.
- The enable is never reasserted before a cycle with enable=0 has elapsed after ready.

## Configuration
- **`ALU_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches `TIMEOUT` without `i_ALU_READY`, go to DONE with `o_ERR`=1; `o_RESULT` is unchanged.
  - A ready pulse in the same cycle as the timeout takes priority, giving a normal completion.
- **Undefined:** ISSUE waits indefinitely; `o_ERR` flags illegal opcodes only, and no counter is built.

## Structure
- Package `alu_arb_pkg` holds:
  - the state encoding;
  - the ALU opcode constants: `ALU_OP_CMP`=3'b001, `ALU_OP_ADD`=3'b010, `ALU_OP_SUB`=3'b100;
  - the legal-opcode check function.
- Sub-module `rr_arbiter`: combinational round-robin pick plus registered pointer, with a pointer-update strobe; parameterised by `NUM_REQ`.

## Test plan
- **Single add:** req1 with add, RX=0x0005, RY=0x0003 → `o_ALU_ENABLE`=010 for 4 cycles, `o_DONE[1]` 4 cycles after request, `o_RESULT`=0x0008, `o_ERR`=0.
- **Round-robin:** all four requesting sub, RX=0x0010, RY=k+1 → grants in order 0,1,2,3 at 5-cycle spacing, results 0x000F, 0x000E, 0x000D, 0x000C; re-requesting req0 is served after req3.
- **Compare and wrap:** compare with RX=0 → `o_RESULT`=1; compare with RX=7 → 0. Sub 0x0000−0x0001 → 0xFFFF; add 0xFFFF+0x0002 → 0x0001.
- **Illegal opcode:** opcode 011 → `o_DONE` and `o_ERR`=1 one cycle after grant, `o_ALU_ENABLE` stays 000, the next requester is then served normally.
- **Timeout** (macro on, TIMEOUT=15, ALU ready tied 0): `o_DONE` with `o_ERR`=1 after 15 ISSUE cycles and enable drops. With the macro off, no `o_DONE` appears within 100 cycles.
- **Reset mid-ISSUE:** assert `i_RESET` for 1 cycle → all outputs 0, no `o_DONE`; the next request to req0 completes with correct latency.
